// File: rtl/sdram_pixel_checker.sv
// sdram_pixel_checker
//   Read-back verifier for the SDRAM frame-buffer test path. After the frame
//   writer reports a stored frame, it issues one read per pixel in raster order,
//   checks each returned pixel against the four-quadrant test pattern
//   (0 / 85 / 170 / 255) and reports a verdict, an error count and the first
//   failing pixel.
//
// Ports
//   clk, reset         system clock; synchronous active-high reset
//   write_finished     frame writer done (level, sampled in IDLE)
//   read_ready         controller accepts a read request this cycle
//   read_request       read request (issued on read_request && read_ready)
//   read_addr          pixel address y*WIDTH+x of the current request
//   read_valid         returned pixel valid (in request order)
//   read_data          returned pixel
//   check_done         verdict available, held until reset
//   check_pass         done, no mismatches and no timeout
//   timeout            DRAIN timed out waiting for responses
//   err_count          number of mismatched pixels
//   first_err_valid    first_err_* fields captured
//   first_err_x/y/data coordinates and data of the first mismatch
module sdram_pixel_checker #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_finished,
    input  logic        read_ready,
    output logic        read_request,
    output logic [18:0] read_addr,
    input  logic        read_valid,
    input  logic [7:0]  read_data,
    output logic        check_done,
    output logic        check_pass,
    output logic        timeout,
    output logic [18:0] err_count,
    output logic        first_err_valid,
    output logic [9:0]  first_err_x,
    output logic [8:0]  first_err_y,
    output logic [7:0]  first_err_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [18:0] LAST_ADDR = 19'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]  LAST_X    = 10'(WIDTH - 1);
    localparam logic [8:0]  LAST_Y    = 9'(HEIGHT - 1);
    localparam logic [9:0]  HALF_X    = 10'(WIDTH / 2);
    localparam logic [8:0]  HALF_Y    = 9'(HEIGHT / 2);
    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [18:0]   addr_q, addr_d;
    logic [9:0]    rx_q, rx_d;
    logic [8:0]    ry_q, ry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          timeout_q, timeout_d;
    logic [18:0]   err_q, err_d;
    logic          fev_q, fev_d;
    logic [9:0]    fex_q, fex_d;
    logic [8:0]    fey_q, fey_d;
    logic [7:0]    fed_q, fed_d;

    logic [7:0]    exp_pix;
    logic          resp_en;

    // Quadrant test pattern for the pixel the next response belongs to.
    always_comb begin
        if (ry_q < HALF_Y) begin
            exp_pix = (rx_q < HALF_X) ? 8'd0 : 8'd85;
        end else begin
            exp_pix = (rx_q < HALF_X) ? 8'd170 : 8'd255;
        end
    end

    // Responses are only tracked while a frame is in flight.
    assign resp_en = read_valid && ((state_q == ST_READ) || (state_q == ST_DRAIN));

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        fev_d     = fev_q;
        fex_d     = fex_q;
        fey_d     = fey_q;
        fed_d     = fed_q;

        case (state_q)
            ST_IDLE: begin
                if (write_finished) begin
                    state_d = ST_READ;
                    req_d   = 1'b1;
                    addr_d  = '0;
                    rx_d    = '0;
                    ry_d    = '0;
                end
            end
            ST_READ: begin
                tmo_d = '0;
                if (req_q && read_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = addr_q + 19'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (read_valid) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response path runs alongside the issue path; the final response
        // overrides any state change made above (including leaving READ early).
        if (resp_en) begin
            if (read_data != exp_pix) begin
                err_d = err_q + 19'd1;
                if (!fev_q) begin
                    fev_d = 1'b1;
                    fex_d = rx_q;
                    fey_d = ry_q;
                    fed_d = read_data;
                end
            end
            if (rx_q == LAST_X) begin
                rx_d = '0;
                if (ry_q == LAST_Y) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ry_d = ry_q + 9'd1;
                end
            end else begin
                rx_d = rx_q + 10'd1;
            end
        end

        // Verdict is latched from next-state values so it appears with check_done.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            pass_d = (err_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            fev_q     <= 1'b0;
            fex_q     <= '0;
            fey_q     <= '0;
            fed_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fev_q     <= fev_d;
            fex_q     <= fex_d;
            fey_q     <= fey_d;
            fed_q     <= fed_d;
        end
    end

    assign read_request    = req_q;
    assign read_addr       = addr_q;
    assign check_done      = done_q;
    assign check_pass      = pass_q;
    assign timeout         = timeout_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_x     = fex_q;
    assign first_err_y     = fey_q;
    assign first_err_data  = fed_q;

endmodule

// File: tb/tb_sdram_pixel_checker.sv
// Testbench for sdram_pixel_checker, using a reduced 32x16 frame and a short
// DRAIN timeout so every scenario completes in a few thousand cycles.
module tb_sdram_pixel_checker;

    localparam int W      = 32;
    localparam int H      = 16;
    localparam int TMO    = 64;
    localparam int N      = W * H;
    localparam int BUDGET = 4 * N + TMO + 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_finished;
    logic        read_ready;
    logic        read_request;
    logic [18:0] read_addr;
    logic        read_valid;
    logic [7:0]  read_data;
    logic        check_done;
    logic        check_pass;
    logic        timeout;
    logic [18:0] err_count;
    logic        first_err_valid;
    logic [9:0]  first_err_x;
    logic [8:0]  first_err_y;
    logic [7:0]  first_err_data;

    always #5 clk = ~clk;

    sdram_pixel_checker #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_finished  (write_finished),
        .read_ready      (read_ready),
        .read_request    (read_request),
        .read_addr       (read_addr),
        .read_valid      (read_valid),
        .read_data       (read_data),
        .check_done      (check_done),
        .check_pass      (check_pass),
        .timeout         (timeout),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_x     (first_err_x),
        .first_err_y     (first_err_y),
        .first_err_data  (first_err_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observations from the last run_frame call.
    int r_req_first;
    int r_hs;
    int r_addr_bad;
    int r_done_cyc;
    int r_last_valid;
    int r_last_hs;
    // Bench model of the result for the last frame.
    int m_err;
    int m_fev;
    int m_fex;
    int m_fey;
    int m_fed;

    function automatic logic [7:0] pattern(input int x, input int y);
        if (y < H / 2) return (x < W / 2) ? 8'd0 : 8'd85;
        return (x < W / 2) ? 8'd170 : 8'd255;
    endfunction

    task automatic apply_reset();
        reset          = 1'b1;
        write_finished = 1'b0;
        read_ready     = 1'b0;
        read_valid     = 1'b0;
        read_data      = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory model + address scoreboard. Called at a negedge; returns at a negedge.
    task automatic run_frame(input bit stall, input int drop, input bit corrupt, input int reset_at);
        int addr_sb[$];
        int due_q[$];
        int resp_q[$];
        int cyc;
        int a;
        int x;
        int y;
        logic [7:0] d;
        r_hs = 0; r_addr_bad = 0; r_done_cyc = -1; r_last_valid = -1; r_last_hs = -1;
        m_err = 0; m_fev = 0; m_fex = 0; m_fey = 0; m_fed = 0;
        for (int i = 0; i < N; i++) addr_sb.push_back(i);
        write_finished = 1'b1;
        read_ready     = 1'b1;
        @(negedge clk);
        write_finished = 1'b0;
        r_req_first    = int'(read_request);
        cyc = 0;
        while (cyc < BUDGET) begin
            if (check_done) begin
                r_done_cyc = cyc;
                break;
            end
            if (reset_at >= 0 && r_hs == reset_at) begin
                reset      = 1'b1;
                read_valid = 1'b0;
                read_ready = 1'b1;
                return;
            end
            read_valid = 1'b0;
            read_data  = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                a = resp_q.pop_front();
                if (a < N - drop) begin
                    x = a % W;
                    y = a / W;
                    d = pattern(x, y);
                    if (corrupt && x == 16 && y == 0) d = 8'h00;
                    if (corrupt && x == 5 && y == 12) d = 8'hFF;
                    read_valid   = 1'b1;
                    read_data    = d;
                    r_last_valid = cyc;
                    if (d != pattern(x, y)) begin
                        m_err++;
                        if (m_fev == 0) begin
                            m_fev = 1; m_fex = x; m_fey = y; m_fed = int'(d);
                        end
                    end
                end
            end
            read_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (read_request) begin
                if (addr_sb.size() == 0 || read_addr !== 19'(addr_sb[0])) r_addr_bad++;
                if (read_ready) begin
                    if (addr_sb.size() > 0) void'(addr_sb.pop_front());
                    due_q.push_back(cyc + 3);
                    resp_q.push_back(int'(read_addr));
                    r_hs++;
                    r_last_hs = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        read_valid = 1'b0;
        read_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({read_request, read_addr, check_done, check_pass, timeout} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: got req=%0b addr=%0d done=%0b pass=%0b tmo=%0b, want all 0",
                     read_request, read_addr, check_done, check_pass, timeout);
        end
        n_vec++;
        if ({err_count, first_err_valid, first_err_x, first_err_y, first_err_data} !== 47'd0) begin
            n_err++;
            $display("FAIL reset_result: got err=%0d fev=%0b x=%0d y=%0d d=%0d, want all 0",
                     err_count, first_err_valid, first_err_x, first_err_y, first_err_data);
        end
    endtask

    task automatic test_ideal();
        apply_reset();
        run_frame(1'b0, 0, 1'b0, -1);
        n_vec++;
        if (r_req_first !== 1) begin
            n_err++; $display("FAIL ideal_first_req: got %0d want 1", r_req_first);
        end
        n_vec++;
        if (r_hs !== N || r_addr_bad !== 0) begin
            n_err++; $display("FAIL ideal_addr: got hs=%0d bad=%0d want hs=%0d bad=0", r_hs, r_addr_bad, N);
        end
        n_vec++;
        if (r_done_cyc !== r_last_valid + 1) begin
            n_err++; $display("FAIL ideal_done_time: got cyc %0d want %0d", r_done_cyc, r_last_valid + 1);
        end
        n_vec++;
        if (check_pass !== 1'b1 || err_count !== 19'd0 || first_err_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL ideal_verdict: got pass=%0b err=%0d fev=%0b tmo=%0b want 1 0 0 0",
                     check_pass, err_count, first_err_valid, timeout);
        end
    endtask

    task automatic test_corrupt();
        apply_reset();
        run_frame(1'b0, 0, 1'b1, -1);
        n_vec++;
        if (check_done !== 1'b1 || check_pass !== 1'b0) begin
            n_err++; $display("FAIL corrupt_verdict: got done=%0b pass=%0b want 1 0", check_done, check_pass);
        end
        n_vec++;
        if (err_count !== 19'd2 || int'(err_count) !== m_err) begin
            n_err++; $display("FAIL corrupt_count: got %0d want 2 (model %0d)", err_count, m_err);
        end
        n_vec++;
        if (first_err_valid !== 1'b1 || first_err_x !== 10'd16 || first_err_y !== 9'd0 || first_err_data !== 8'h00) begin
            n_err++;
            $display("FAIL corrupt_first: got v=%0b x=%0d y=%0d d=%0h want 1 16 0 00",
                     first_err_valid, first_err_x, first_err_y, first_err_data);
        end
    endtask

    // Runs right after test_corrupt, while the block sits in DONE with err_count=2.
    task automatic test_done_ignores();
        for (int i = 0; i < 10; i++) begin
            read_valid     = 1'b1;
            read_data      = 8'h5A;
            write_finished = (i % 2 == 0);
            read_ready     = 1'b1;
            @(negedge clk);
        end
        read_valid = 1'b0; write_finished = 1'b0;
        @(negedge clk);
        n_vec++;
        if (check_done !== 1'b1 || check_pass !== 1'b0 || read_request !== 1'b0 || err_count !== 19'd2 ||
            first_err_x !== 10'd16 || first_err_y !== 9'd0 || first_err_data !== 8'h00) begin
            n_err++;
            $display("FAIL done_frozen: got done=%0b pass=%0b req=%0b err=%0d x=%0d y=%0d d=%0h want 1 0 0 2 16 0 00",
                     check_done, check_pass, read_request, err_count, first_err_x, first_err_y, first_err_data);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        run_frame(1'b1, 0, 1'b0, -1);
        n_vec++;
        if (r_hs !== N || r_addr_bad !== 0) begin
            n_err++; $display("FAIL stall_addr: got hs=%0d bad=%0d want hs=%0d bad=0", r_hs, r_addr_bad, N);
        end
        n_vec++;
        if (check_pass !== 1'b1 || err_count !== 19'd0 || r_done_cyc !== r_last_valid + 1) begin
            n_err++;
            $display("FAIL stall_verdict: got pass=%0b err=%0d done_cyc=%0d want 1 0 %0d",
                     check_pass, err_count, r_done_cyc, r_last_valid + 1);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        run_frame(1'b0, 5, 1'b0, -1);
        n_vec++;
        if (timeout !== 1'b1 || check_done !== 1'b1 || check_pass !== 1'b0) begin
            n_err++; $display("FAIL drop_verdict: got tmo=%0b done=%0b pass=%0b want 1 1 0", timeout, check_done, check_pass);
        end
        n_vec++;
        if (err_count !== 19'd0 || first_err_valid !== 1'b0) begin
            n_err++; $display("FAIL drop_count: got err=%0d fev=%0b want 0 0", err_count, first_err_valid);
        end
        n_vec++;
        if (r_done_cyc !== r_last_hs + TMO + 1) begin
            n_err++; $display("FAIL drop_time: got cyc %0d want %0d", r_done_cyc, r_last_hs + TMO + 1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_frame(1'b0, 0, 1'b0, 40);
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({read_request, read_addr, check_done, check_pass, timeout, err_count,
             first_err_valid, first_err_x, first_err_y, first_err_data} !== 70'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got req=%0b addr=%0d done=%0b err=%0d fev=%0b want all 0",
                     read_request, read_addr, check_done, err_count, first_err_valid);
        end
        // Stragglers from the aborted frame, plus bad data, arrive in IDLE.
        for (int i = 0; i < 6; i++) begin
            read_valid = 1'b1;
            read_data  = 8'h33;
            @(negedge clk);
        end
        read_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (read_request !== 1'b0 || err_count !== 19'd0 || first_err_valid !== 1'b0 || check_done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignores: got req=%0b err=%0d fev=%0b done=%0b want 0 0 0 0",
                     read_request, err_count, first_err_valid, check_done);
        end
        run_frame(1'b0, 0, 1'b0, -1);
        n_vec++;
        if (check_pass !== 1'b1 || err_count !== 19'd0 || r_hs !== N || r_addr_bad !== 0) begin
            n_err++;
            $display("FAIL rerun: got pass=%0b err=%0d hs=%0d bad=%0d want 1 0 %0d 0",
                     check_pass, err_count, r_hs, r_addr_bad, N);
        end
    endtask

    initial begin
        reset = 1'b1; write_finished = 1'b0; read_ready = 1'b0; read_valid = 1'b0; read_data = '0;
        @(negedge clk);
        test_reset();
        test_ideal();
        test_corrupt();
        test_done_ignores();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
